uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Sequencer and round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers. Accepts bytes over per-requester valid/ready handshakes, issues one-cycle write pulses to the transmitter, and tracks its busy flag so each byte is fully serialized before the next is issued. Supports packet locking: a requester keeps the transmitter until it sends a byte marked last.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- IDW, $clog2(NUM_REQ): width of grant_id.
- CLK  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  8*NUM_REQ  byte i on bits [8i+7:8i].
- req_last  in  NUM_REQ  byte ends requester's packet; releases lock.
- req_ready  out  NUM_REQ  one-hot accept strobe; at most one bit high.
- tx_din  out  8  byte to transmitter, registered.
- tx_wr_en  out  1  one-cycle write pulse to transmitter.
- tx_busy  in  1  transmitter busy flag (high from the cycle after wr_en until stop bit done).
- grant_id  out  IDW  index of current or most recent owner.
- locked  out  1  packet lock held.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: RESYNC, IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- RESYNC: entered on rst. The transmitter has no reset, so stay here until tx_busy==0, then go to IDLE.
- IDLE: the winner is computed combinationally.
  - Unlocked: first i with req_valid[i]==1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Locked: owner only. Other requesters are ignored even if valid.
  - req_ready[winner]=1 while in IDLE and the winner's valid is high.
  - Accept when valid&ready: register data into tx_din, set grant_id=winner, go to ISSUE.
- ISSUE: tx_wr_en=1 for exactly this cycle, then WAIT_BUSY.
- WAIT_BUSY: wait for tx_busy==1, then WAIT_DONE.
  - Watchdog: if tx_busy is not seen within 4 cycles of entering, return to ISSUE and re-pulse (the transmitter was not idle when written).
- WAIT_DONE: wait for tx_busy==0, then IDLE.
- Lock and pointer update, applied on accept:
  - req_last==0: locked<=1, owner<=winner; rr_ptr unchanged.
  - req_last==1: locked<=0; rr_ptr<=(winner+1) mod NUM_REQ.
- Owner drops valid while locked: wait indefinitely. No timeout, no preemption.
- req_data and req_last are sampled only in the accept cycle. Changes at other times are ignored.

## Timing
- Reset values:
  - state=RESYNC, tx_wr_en=0, tx_din=8'h00, req_ready=0, grant_id=0, locked=0, rr_ptr=0, busy=1.
- Byte latency:
  - Accept at cycle T; tx_wr_en high at T+1; tx_busy expected high at T+2.
  - Return to IDLE the cycle after tx_busy falls.
  - The next accept can occur in that IDLE cycle.
- req_ready is never high outside IDLE and never high in RESYNC.
- Simultaneous valids: only the winner gets ready; losers hold valid and data.
- rst mid-transfer (any state): all registers take reset values on the next edge, and any in-flight tx_wr_en is dropped. RESYNC then waits out the transmitter's current frame before IDLE.
- rr_ptr wraps from NUM_REQ-1 to 0.

## Structure
- Shared package uart_pkg holds:
  - the scheduler state enum (RESYNC, IDLE, ISSUE, WAIT_BUSY, WAIT_DONE);
  - the watchdog limit constant (4);
  - the data width constant (8).
- One sub-module, uart_rr_arbiter: combinational rotating-priority pick.
  - Inputs: request vector, rr_ptr, lock mask.
  - Outputs: one-hot grant and index.
  - Instantiated once.

## Test plan
- Single requester: req 0 sends 8'hA5 with last=1.
  - Expect: ready at T, tx_wr_en at T+1 with tx_din=8'hA5, serial frame 0,1010_0101 LSB-first, 1, then IDLE; rr_ptr=1.
- Round-robin: all 4 requesters continuously valid, last=1, data=8'h10+i.
  - Expect: grant order 0,1,2,3,0; exactly one ready per frame; never two wr_en pulses within one frame.
- Packet lock: req 2 sends 3 bytes (last on the third) while req 1 is valid throughout.
  - Expect: req 1 is not granted until req 2's third byte is accepted; locked=1 across the first two bytes, then 0.
- Locked stall: owner deasserts valid for 50 cycles mid-packet while others are valid.
  - Expect: no grant to others, no wr_en, locked stays 1, busy=0.
- Reset mid-frame: rst asserted during WAIT_DONE while the transmitter is still busy.
  - Expect: outputs at reset values, state RESYNC until tx_busy falls, no req_ready during that window, then normal operation with rr_ptr=0.
- Watchdog: tx_busy model held low after wr_en.
  - Expect: re-pulse of tx_wr_en 5 cycles after the first, with the same tx_din.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// No logic; imported by the scheduler top and its arbiter.
package uart_pkg;

  localparam int DATA_W   = 8;
  localparam int WD_LIMIT = 4;
  localparam int WD_W     = $clog2(WD_LIMIT + 1);

  typedef enum logic [2:0] {
    RESYNC,
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } sched_state_t;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Rotating-priority pick starting at rr_ptr over req & lock_mask; purely combinational, zero latency.
// No backpressure of its own: the grant is only a proposal until the scheduler accepts it.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  input  logic [NUM_REQ-1:0] lock_mask,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               grant_vld
);

  logic [NUM_REQ-1:0] masked;
  logic [IDW:0]       pos;
  logic [IDW-1:0]     idx;

  assign masked = req & lock_mask;

  // pos carries one extra bit so rr_ptr + k never overflows before the wrap.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    pos       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(NUM_REQ)) begin
        pos = pos - (IDW+1)'(NUM_REQ);
      end
      idx = pos[IDW-1:0];
      if (!grant_vld && masked[idx]) begin
        grant_vld  = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ producers; accept-to-wr_en is 1 cycle, next accept the cycle after tx_busy falls.
// Producers are held off (req_ready low) outside IDLE; a locked packet holds the transmitter until its last byte.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         tx_din,
  output logic                      tx_wr_en,
  input  logic                      tx_busy,
  output logic [IDW-1:0]            grant_id,
  output logic                      locked,
  output logic                      busy
);

  sched_state_t state, state_nxt;

  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     owner;
  logic [WD_W-1:0]    wd_cnt;
  logic [NUM_REQ-1:0] lock_mask;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDW-1:0]     arb_idx;
  logic               arb_vld;
  logic               accept;
  logic               wd_expired;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_last;
  logic [IDW-1:0]     ptr_after;

  assign lock_mask  = locked ? (NUM_REQ'(1) << owner) : '1;
  assign sel_data   = req_data[arb_idx*DATA_W +: DATA_W];
  assign sel_last   = req_last[arb_idx];
  assign ptr_after  = (arb_idx == IDW'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
  assign wd_expired = (wd_cnt == WD_W'(WD_LIMIT-1));
  assign busy       = (state != IDLE);

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .lock_mask (lock_mask),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= RESYNC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    tx_wr_en  = 1'b0;
    accept    = 1'b0;
    case (state)
      // The transmitter is never reset, so let any frame in flight finish first.
      RESYNC: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      IDLE: begin
        req_ready = arb_grant;
        accept    = arb_vld;
        if (arb_vld) state_nxt = ISSUE;
      end
      ISSUE: begin
        tx_wr_en  = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      // No busy response means the write was dropped; pulse again with the same byte.
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (wd_expired) begin
          state_nxt = ISSUE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = RESYNC;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      tx_din   <= '0;
      grant_id <= '0;
      locked   <= 1'b0;
      owner    <= '0;
      rr_ptr   <= '0;
      wd_cnt   <= '0;
    end else begin
      if (accept) begin
        tx_din   <= sel_data;
        grant_id <= arb_idx;
        if (sel_last) begin
          locked <= 1'b0;
          rr_ptr <= ptr_after;
        end else begin
          locked <= 1'b1;
          owner  <= arb_idx;
        end
      end
      if (state == ISSUE) begin
        wd_cnt <= '0;
      end else if (state == WAIT_BUSY && !tx_busy && !wd_expired) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a 1-cycle-per-bit transmitter model.
// Covers reset, single byte framing, round-robin, packet lock, locked stall, mid-frame reset and watchdog.
module tb_uart_tx_scheduler;

  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;

  logic                CLK = 1'b0;
  logic                rst;
  logic [NUM_REQ-1:0]  req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]  req_last;
  logic [NUM_REQ-1:0]  req_ready;
  logic [7:0]          tx_din;
  logic                tx_wr_en;
  logic                tx_busy;
  logic [IDW-1:0]      grant_id;
  logic                locked;
  logic                busy;

  int errors = 0;
  int checks = 0;

  int         tx_cnt   = 0;
  logic [9:0] tx_shift = '1;
  bit         tx_dead  = 1'b0;
  logic       tx_line;

  always #5 CLK = ~CLK;

  uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .IDW(IDW)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_din    (tx_din),
    .tx_wr_en  (tx_wr_en),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .locked    (locked),
    .busy      (busy)
  );

  // Transmitter model: one bit per cycle, start + 8 data + stop, ignores writes while busy or dead.
  always @(posedge CLK) begin
    if (tx_wr_en && tx_cnt == 0 && !tx_dead) begin
      tx_shift <= {1'b1, tx_din, 1'b0};
      tx_cnt   <= 10;
    end else if (tx_cnt > 0) begin
      tx_shift <= {1'b1, tx_shift[9:1]};
      tx_cnt   <= tx_cnt - 1;
    end
  end
  assign tx_busy = (tx_cnt != 0);
  assign tx_line = (tx_cnt != 0) ? tx_shift[0] : 1'b1;

  `define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s: observed=%0h expected=%0h", tag, (obs), (exp)); end end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input int budget, output int pulses);
    int n;
    n = 0;
    pulses = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      if (tx_wr_en === 1'b1) pulses++;
      n++;
    end
    `CHK("wait_idle_timeout", busy, 1'b0)
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          pulses;
    int          bad;
    int          n;
    logic [9:0]  frame;
    logic [3:0]  exp_rdy;
    int          exp_ord [6] = '{1, 2, 3, 0, 1, 2};

    // Reset with all requesters valid: nothing may be granted.
    rst       = 1'b1;
    req_valid = 4'hF;
    req_data  = '0;
    req_last  = '0;
    tick();
    tick();
    `CHK("rst_wr_en", tx_wr_en, 1'b0)
    `CHK("rst_din", tx_din, 8'h00)
    `CHK("rst_ready", req_ready, 4'b0000)
    `CHK("rst_grant", grant_id, 2'd0)
    `CHK("rst_locked", locked, 1'b0)
    `CHK("rst_busy", busy, 1'b1)
    rst       = 1'b0;
    req_valid = 4'h0;
    tick();
    `CHK("resync_to_idle", busy, 1'b0)

    // Single byte from requester 0 and its serial frame.
    req_valid = 4'b0001;
    req_data  = 32'h0000_00A5;
    req_last  = 4'b0001;
    #1;
    `CHK("single_ready", req_ready, 4'b0001)
    tick();
    req_valid = 4'b0000;
    `CHK("single_wr_en", tx_wr_en, 1'b1)
    `CHK("single_din", tx_din, 8'hA5)
    `CHK("single_ready_after", req_ready, 4'b0000)
    for (int i = 0; i < 10; i++) begin
      tick();
      frame[i] = tx_line;
    end
    `CHK("single_frame", frame, 10'b1101001010)
    tick();
    `CHK("single_txbusy_fell", tx_busy, 1'b0)
    `CHK("single_busy_still", busy, 1'b1)
    tick();
    `CHK("single_idle", busy, 1'b0)
    `CHK("single_locked", locked, 1'b0)

    // Round-robin: rr_ptr is 1 after the single byte.
    req_valid = 4'hF;
    req_data  = 32'h1312_1110;
    req_last  = 4'hF;
    for (int f = 0; f < 6; f++) begin
      #1;
      exp_rdy = 4'b0001 << exp_ord[f];
      `CHK("rr_ready", req_ready, exp_rdy)
      tick();
      `CHK("rr_wr_en", tx_wr_en, 1'b1)
      `CHK("rr_din", tx_din, 8'(8'h10 + exp_ord[f]))
      `CHK("rr_grant", grant_id, 2'(exp_ord[f]))
      wait_idle(40, pulses);
      `CHK("rr_single_pulse", pulses, 0)
    end
    req_valid = 4'h0;

    // Packet lock: rr_ptr=3 would favour req 1 over req 2 if unlocked.
    req_valid = 4'b0100;
    req_data  = 32'h00C0_0000;
    req_last  = 4'b0000;
    #1;
    `CHK("lock_ready0", req_ready, 4'b0100)
    tick();
    `CHK("lock_locked0", locked, 1'b1)
    `CHK("lock_grant0", grant_id, 2'd2)
    req_valid = 4'b0110;
    req_data  = 32'h00C1_7700;
    req_last  = 4'b0010;
    wait_idle(40, pulses);
    `CHK("lock_din_hold", tx_din, 8'hC0)
    `CHK("lock_ready1", req_ready, 4'b0100)
    tick();
    `CHK("lock_din1", tx_din, 8'hC1)
    `CHK("lock_locked1", locked, 1'b1)
    req_data = 32'h00C2_7700;
    req_last = 4'b0110;
    wait_idle(40, pulses);
    `CHK("lock_ready2", req_ready, 4'b0100)
    tick();
    `CHK("lock_din2", tx_din, 8'hC2)
    `CHK("lock_released", locked, 1'b0)
    req_valid = 4'b0010;
    wait_idle(40, pulses);
    `CHK("lock_other_ready", req_ready, 4'b0010)
    tick();
    `CHK("lock_other_din", tx_din, 8'h77)
    `CHK("lock_other_grant", grant_id, 2'd1)
    req_valid = 4'b0000;
    wait_idle(40, pulses);

    // Locked stall: req 3 opens a packet then drops valid for 50 cycles.
    req_valid = 4'b1000;
    req_data  = 32'h3A00_0000;
    req_last  = 4'b0000;
    #1;
    `CHK("stall_ready0", req_ready, 4'b1000)
    tick();
    `CHK("stall_locked0", locked, 1'b1)
    req_valid = 4'b0000;
    wait_idle(40, pulses);
    req_valid = 4'b0111;
    req_data  = 32'h3B33_2211;
    req_last  = 4'b1111;
    #1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready !== 4'b0000 || tx_wr_en !== 1'b0 || locked !== 1'b1 || busy !== 1'b0) bad++;
      tick();
    end
    `CHK("stall_bad_cycles", bad, 0)
    `CHK("stall_locked", locked, 1'b1)
    `CHK("stall_busy", busy, 1'b0)
    req_valid = 4'b1111;
    #1;
    `CHK("stall_owner_ready", req_ready, 4'b1000)
    tick();
    `CHK("stall_owner_din", tx_din, 8'h3B)
    `CHK("stall_unlocked", locked, 1'b0)
    req_valid = 4'b0000;
    wait_idle(40, pulses);

    // Reset mid-frame while a lock is held (rr_ptr=0 before and after).
    req_valid = 4'b0100;
    req_data  = 32'h005A_0000;
    req_last  = 4'b0000;
    #1;
    `CHK("mrst_ready", req_ready, 4'b0100)
    tick();
    req_valid = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
    `CHK("mrst_pre_txbusy", tx_busy, 1'b1)
    `CHK("mrst_pre_locked", locked, 1'b1)
    rst       = 1'b1;
    req_valid = 4'hF;
    req_data  = 32'h0000_00E1;
    req_last  = 4'hF;
    tick();
    `CHK("mrst_wr_en", tx_wr_en, 1'b0)
    `CHK("mrst_din", tx_din, 8'h00)
    `CHK("mrst_ready0", req_ready, 4'b0000)
    `CHK("mrst_grant", grant_id, 2'd0)
    `CHK("mrst_locked", locked, 1'b0)
    `CHK("mrst_busy", busy, 1'b1)
    rst = 1'b0;
    bad = 0;
    n   = 0;
    while (tx_busy === 1'b1 && n < 30) begin
      if (req_ready !== 4'b0000 || busy !== 1'b1) bad++;
      tick();
      n++;
    end
    `CHK("mrst_txbusy_timeout", tx_busy, 1'b0)
    `CHK("mrst_resync_window", bad, 0)
    `CHK("mrst_still_resync", busy, 1'b1)
    `CHK("mrst_still_noready", req_ready, 4'b0000)
    tick();
    `CHK("mrst_ready_ptr0", req_ready, 4'b0001)
    tick();
    `CHK("mrst_din_after", tx_din, 8'hE1)
    `CHK("mrst_grant_after", grant_id, 2'd0)
    req_valid = 4'b0000;
    wait_idle(40, pulses);

    // Watchdog: transmitter ignores the first write, expect a re-pulse 5 cycles later.
    tx_dead   = 1'b1;
    req_valid = 4'b0010;
    req_data  = 32'h0000_5C00;
    req_last  = 4'b0010;
    #1;
    `CHK("wd_ready", req_ready, 4'b0010)
    tick();
    req_valid = 4'b0000;
    `CHK("wd_wr_en0", tx_wr_en, 1'b1)
    `CHK("wd_din0", tx_din, 8'h5C)
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (tx_wr_en === 1'b1) pulses++;
    end
    `CHK("wd_gap", pulses, 0)
    tick();
    `CHK("wd_wr_en1", tx_wr_en, 1'b1)
    `CHK("wd_din1", tx_din, 8'h5C)
    tx_dead = 1'b0;
    wait_idle(40, pulses);
    `CHK("wd_no_extra", pulses, 0)
    `CHK("wd_grant", grant_id, 2'd1)

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
